muldiv_seq: RTL

- Multi-cycle RV32M multiply/divide sequencer for the execute stage.
- Runs shift-add multiply and restoring divide through ONE shared 33-bit ripple adder/subtractor built from fulladder cells.
- Pipeline stalls while busy=1; result is consumed on done.
- Fixed latency for every op and operand value, so hazard logic can count cycles.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_seq_adder.sv | 35 +++
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int unsigned MULDIV_LATENCY = 37;
    localparam logic [31:0] DIV0_QUOT      = 32'hFFFF_FFFF;

    // rs1 is treated as signed by these ops
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // rs2 is treated as signed by these ops
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_adder.sv
// Full-adder cell and the 33-bit ripple adder built from it.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_adder33 (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        cin,
    output logic [32:0] sum,
    output logic        cout
);
    logic [33:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 33; i++) begin : g_bit
        fulladder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[33];
endmodule

// File: rtl/muldiv_seq.sv
// Fixed-latency RV32M multiply/divide sequencer sharing one ripple adder.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(ITERS);

    state_t          state, state_nx;
    logic [2:0]      op_r;
    logic [XLEN-1:0] a_r, b_r, a_orig, acc, lo;
    logic            neg_a_r, neg_b_r, div0_r, ovf_r, carry_r;
    logic [CW-1:0]   count;

    logic [32:0]     add_x, add_y, add_s;
    logic            add_ci, add_co;

    logic            is_mul, is_rem, sgn;

    assign is_mul = ~op_r[2];
    assign is_rem = op_r[2] & op_r[1];
    assign sgn    = is_rem ? neg_a_r : (neg_a_r ^ neg_b_r);

    ripple_adder33 u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_ci),
        .sum  (add_s),
        .cout (add_co)
    );

    // state register and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
        end
    end

    // next state and per-state adder operand selection
    always_comb begin
        state_nx = state;
        add_x    = '0;
        add_y    = '0;
        add_ci   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = NEG_A;
            end
            NEG_A: begin
                add_x    = {1'b0, ~a_r};
                add_ci   = 1'b1;
                state_nx = NEG_B;
            end
            NEG_B: begin
                add_x    = {1'b0, ~b_r};
                add_ci   = 1'b1;
                state_nx = ITER;
            end
            ITER: begin
                if (is_mul) begin
                    add_x = {1'b0, acc};
                    add_y = lo[0] ? {1'b0, b_r} : 33'd0;
                end else begin
                    add_x  = {acc, lo[XLEN-1]};
                    add_y  = ~{1'b0, b_r};
                    add_ci = 1'b1;
                end
                if (count == CW'(ITERS - 1)) state_nx = FIX_LO;
            end
            FIX_LO: begin
                add_x    = {1'b0, ~(is_rem ? acc : lo)};
                add_ci   = 1'b1;
                state_nx = FIX_HI;
            end
            FIX_HI: begin
                add_x    = {1'b0, ~acc};
                add_ci   = carry_r;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand, product/remainder and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            a_orig  <= '0;
            acc     <= '0;
            lo      <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            div0_r  <= 1'b0;
            ovf_r   <= 1'b0;
            carry_r <= 1'b0;
            count   <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        a_orig  <= a;
                        neg_a_r <= op_a_signed(op) & a[XLEN-1];
                        neg_b_r <= op_b_signed(op) & b[XLEN-1];
                        div0_r  <= (b == '0);
                        ovf_r   <= (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                    end
                end
                NEG_A: begin
                    if (neg_a_r) a_r <= add_s[XLEN-1:0];
                end
                NEG_B: begin
                    if (neg_b_r) b_r <= add_s[XLEN-1:0];
                    acc   <= '0;
                    lo    <= a_r;
                    count <= '0;
                end
                ITER: begin
                    count <= count + CW'(1);
                    if (is_mul) begin
                        acc <= add_s[32:1];
                        lo  <= {add_s[0], lo[XLEN-1:1]};
                    end else if (add_co) begin
                        acc <= add_s[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc <= {acc[XLEN-2:0], lo[XLEN-1]};
                        lo  <= {lo[XLEN-2:0], 1'b0};
                    end
                end
                FIX_LO: begin
                    carry_r <= add_s[32];
                    if (sgn) begin
                        if (is_rem) acc <= add_s[XLEN-1:0];
                        else        lo  <= add_s[XLEN-1:0];
                    end
                end
                FIX_HI: begin
                    case (op_r)
                        OP_MUL:                       result <= lo;
                        OP_MULH, OP_MULHSU, OP_MULHU: result <= sgn ? add_s[XLEN-1:0] : acc;
                        OP_DIV, OP_DIVU: begin
                            if (div0_r)                        result <= DIV0_QUOT;
                            else if (ovf_r && op_r == OP_DIV)  result <= 32'h8000_0000;
                            else                               result <= lo;
                        end
                        default: begin
                            if (div0_r)                        result <= a_orig;
                            else if (ovf_r && op_r == OP_REM)  result <= '0;
                            else                               result <= acc;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
